// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of a single-port SRAM with a one-cycle read tag.
// Define SRAM_ARB_ROUND_ROBIN_EN for round-robin contention; otherwise port 0 wins.
module sram_arbiter #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    input  logic                  req0_wr,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    output logic                  req0_ready,
    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] rsp0_rdata,
    input  logic                  req1_valid,
    input  logic                  req1_wr,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  req1_ready,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp1_rdata,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic                  sram_csen_n,
    output logic                  sram_wren_n,
    output logic [DATA_WIDTH-1:0] sram_data_i,
    input  logic [DATA_WIDTH-1:0] sram_data_o
);

    logic rsp_vld_q, rsp_vld_d;
    logic rsp_port_q, rsp_port_d;
    logic gnt0, gnt1, prio0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    logic last_q, last_d;
`endif

    always_comb begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        // last_q=1 means port 1 was granted last, so port 0 now has priority
        prio0 = last_q;
`else
        prio0 = 1'b1;
`endif
        gnt0 = rst_n & req0_valid & (~req1_valid | prio0);
        gnt1 = rst_n & req1_valid & ~gnt0;

        req0_ready  = gnt0;
        req1_ready  = gnt1;
        sram_csen_n = 1'b1;
        sram_wren_n = 1'b1;
        sram_addr   = '0;
        sram_data_i = '0;
        if (gnt0) begin
            sram_csen_n = 1'b0;
            sram_wren_n = ~req0_wr;
            sram_addr   = req0_addr;
            sram_data_i = req0_wdata;
        end else if (gnt1) begin
            sram_csen_n = 1'b0;
            sram_wren_n = ~req1_wr;
            sram_addr   = req1_addr;
            sram_data_i = req1_wdata;
        end

        rsp_vld_d  = (gnt0 & ~req0_wr) | (gnt1 & ~req1_wr);
        rsp_port_d = gnt1;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        last_d = last_q;
        if (gnt0) begin
            last_d = 1'b0;
        end else if (gnt1) begin
            last_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_vld_q  <= 1'b0;
            rsp_port_q <= 1'b0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            last_q     <= 1'b1;
`endif
        end else begin
            rsp_vld_q  <= rsp_vld_d;
            rsp_port_q <= rsp_port_d;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            last_q     <= last_d;
`endif
        end
    end

    // Responses are masked during reset so a stale tag never leaks out
    always_comb begin
        rsp0_valid = rst_n & rsp_vld_q & ~rsp_port_q;
        rsp1_valid = rst_n & rsp_vld_q & rsp_port_q;
        rsp0_rdata = rsp0_valid ? sram_data_o : '0;
        rsp1_rdata = rsp1_valid ? sram_data_o : '0;
    end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 4, giving the SRAM address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, giving the SRAM data width.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit, synchronous active-low reset.
REQ-005 The block SHALL have, for each requester N in {0,1}, port reqN_valid, input, 1 bit, a command present.
REQ-006 The block SHALL have, for each N, port reqN_wr, input, 1 bit, 1=write and 0=read.
REQ-007 The block SHALL have, for each N, port reqN_addr, input, ADDR_WIDTH bits, the command address.
REQ-008 The block SHALL have, for each N, port reqN_wdata, input, DATA_WIDTH bits, the write data.
REQ-009 The block SHALL have, for each N, port reqN_ready, output, 1 bit, command accepted this cycle.
REQ-010 The block SHALL have, for each N, port rspN_valid, output, 1 bit, read data present.
REQ-011 The block SHALL have, for each N, port rspN_rdata, output, DATA_WIDTH bits, the read data.
REQ-012 The block SHALL have port sram_addr, output, ADDR_WIDTH bits, the SRAM address.
REQ-013 The block SHALL have port sram_csen_n, output, 1 bit, SRAM chip select, active low.
REQ-014 The block SHALL have port sram_wren_n, output, 1 bit, SRAM write enable, active low (1=read).
REQ-015 The block SHALL have port sram_data_i, output, DATA_WIDTH bits, the SRAM write data.
REQ-016 The block SHALL have port sram_data_o, input, DATA_WIDTH bits, registered SRAM read data, valid one cycle after the read command.

Function
REQ-017 The block SHALL accept at most one command per cycle; a command transfers when reqN_valid and reqN_ready are both 1.
REQ-018 reqN_ready SHALL be combinational: 1 only for the granted port, and only when that port's reqN_valid is 1.
REQ-019 With exactly one valid requester, that requester SHALL be granted in the same cycle.
REQ-020 With both requesters valid, arbitration SHALL follow REQ-034/REQ-035.
REQ-021 In a grant cycle the block SHALL drive combinationally: sram_csen_n=0, sram_wren_n=~reqN_wr, sram_addr=reqN_addr, sram_data_i=reqN_wdata.
REQ-022 With no grant, the block SHALL drive sram_csen_n=1 and sram_wren_n=1, and hold sram_addr and sram_data_i at 0.
REQ-023 An accepted read SHALL assert rspN_valid for exactly one cycle, in the cycle after acceptance, to the issuing port only.
REQ-024 rspN_rdata SHALL equal sram_data_o while rspN_valid=1, and SHALL be 0 otherwise.
REQ-025 An accepted write SHALL produce no response.
REQ-026 Back-to-back reads, from either port, SHALL sustain one per cycle with no bubble.
REQ-027 A read to an address written in the previous cycle SHALL return the new data, because the SRAM write completes at the edge where the write was issued.
REQ-028 A one-bit registered response tag (valid, port) SHALL track the in-flight read.
REQ-029 A requester that holds reqN_valid SHALL keep its command stable until it is accepted; the block does not check this.

Reset
REQ-030 While rst_n=0 at a rising edge, the block SHALL clear all registers: response tag valid=0 and last-grant pointer=1, so port 0 wins the first contention.
REQ-031 While rst_n=0, reqN_ready=0, rspN_valid=0, rspN_rdata=0, sram_csen_n=1 and sram_wren_n=1, independent of the inputs.
REQ-032 A read accepted in the cycle before reset is asserted SHALL be dropped, with no rspN_valid after reset.
REQ-033 The first grant SHALL be possible in the first cycle with rst_n=1.

Configuration
REQ-034 With macro SRAM_ARB_ROUND_ROBIN_EN defined, contention SHALL grant the port not recorded in the last-grant pointer, and the pointer SHALL update to the granted port on every grant.
REQ-035 Without SRAM_ARB_ROUND_ROBIN_EN, port 0 SHALL always win contention and the last-grant pointer SHALL be absent.

Verification
REQ-036 Reset, then req0 write addr 3 data 0xA5, then req0 read addr 3 -> sram_csen_n=0 and sram_wren_n=0 in the write cycle, and rsp0_valid=1 with rsp0_rdata=0xA5 exactly one cycle after the read is accepted.
REQ-037 Both ports reading continuously for 4 cycles, with round-robin enabled -> grants 0,1,0,1 and rsp valid alternating, with 4 responses in 5 cycles.
REQ-038 Same stimulus as REQ-037 with the macro undefined -> port 0 granted 4 times, req1_ready=0 throughout, and no rsp1_valid.
REQ-039 req1 writes addr 15 data 0x3C in cycle t, req0 reads addr 15 in cycle t+1 -> rsp0_rdata=0x3C in cycle t+2.
REQ-040 Read accepted in cycle t, rst_n=0 at edge t+1 -> rsp0_valid=0 in every cycle after, and sram_csen_n=1 during reset.
REQ-041 No valid requests for 3 cycles -> sram_csen_n=1, sram_wren_n=1, both ready=0, and both rsp_valid=0.
